comms_tx_arbiter: RTL

Round-robin transmit scheduler for the 256-bit serial comms link. It shares one link transmitter between NREQ on-chip requesters and sequences each frame. Per frame it picks a requester, loads its frame into sendBuffer, raises readyForSend, and pulses startTransfer. It then waits for link completion or a timeout and acknowledges the requester. It sits between the application blocks and the comms link's sendBuffer/startTransfer/readyForSend inputs.

---
 rtl/comms_tx_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/comms_tx_arbiter.sv
// Round-robin scheduler that shares one serial link transmitter between NREQ requesters.
// Outputs are registered from the current state. rst is asynchronous and active-low.
module comms_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 256,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       reqValid,
  input  logic [NREQ*WIDTH-1:0] reqData,
  output logic [NREQ-1:0]       reqAck,
  output logic                  reqErr,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  input  logic                  linkReady,
  input  logic                  linkDone,
  output logic [WIDTH-1:0]      sendBuffer,
  output logic                  readyForSend,
  output logic                  startTransfer
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(START_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

  state_t        state, stateNext;
  logic [IW-1:0] ptr, winner, pick, cand;
  logic [SW-1:0] startCnt;
  logic [TW-1:0] timer;
  logic          err;
  logic [NREQ-1:0] ownerVec;

  assign ownerVec = {{(NREQ-1){1'b0}}, 1'b1} << winner;

  // Scan downward so the last hit is the closest set bit at or above ptr.
  always_comb begin
    pick = ptr;
    cand = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (reqValid[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (|reqValid && linkReady) stateNext = LOAD;
      LOAD:    stateNext = START;
      START:   if (startCnt == SW'(START_CYCLES - 1)) stateNext = WAIT;
      WAIT:    if (linkDone || timer == TW'(TIMEOUT)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // err is rewritten every WAIT cycle; only its value on the exit edge matters,
  // which gives linkDone priority over a simultaneous timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr           <= '0;
      winner        <= '0;
      startCnt      <= '0;
      timer         <= '0;
      err           <= 1'b0;
      grant         <= '0;
      sendBuffer    <= '0;
      readyForSend  <= 1'b0;
      startTransfer <= 1'b0;
      reqAck        <= '0;
      reqErr        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (state == IDLE) winner <= pick;
      if (state == LOAD) begin
        startCnt   <= '0;
        timer      <= '0;
        sendBuffer <= reqData[int'(winner)*WIDTH +: WIDTH];
      end
      if (state == START) startCnt <= startCnt + SW'(1);
      if (state == WAIT) begin
        err <= ~linkDone;
        if (timer != TW'(TIMEOUT)) timer <= timer + TW'(1);
      end
      if (state == DONE) ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);

      grant         <= (state == IDLE) ? '0 : ownerVec;
      readyForSend  <= (state == LOAD) || (state == START) || (state == WAIT);
      startTransfer <= (state == START);
      reqAck        <= (state == DONE) ? ownerVec : '0;
      reqErr        <= (state == DONE) ? err : 1'b0;
      busy          <= (state != IDLE);
    end
  end

endmodule
